// File: rtl/jtcps1_obj_pkg.sv
// Shared constants and helpers for the object line-buffer scan-out.
// The flip read addressing is used only when JTCPS1_OBJ_FLIP_EN is defined.
package jtcps1_obj_pkg;

  localparam logic [8:0]  OBJ_MAXH   = 9'd448;
  localparam logic [3:0]  OBJ_TRANSP = 4'hF;
  localparam logic [8:0]  OBJ_CLR    = 9'h1FF;
  localparam int unsigned PAL_W      = 5;
  localparam int unsigned COL_W      = 4;

  typedef struct packed {
    logic [PAL_W-1:0] pal;
    logic [COL_W-1:0] col;
  } obj_pxl_t;

  // Mirror only the visible span; the hidden tail keeps its own address.
  function automatic logic [8:0] obj_rd_addr(input logic [8:0] h, input logic flip,
                                             input logic [8:0] maxh);
    return (flip && (h < maxh)) ? (maxh - 9'd1 - h) : h;
  endfunction

endpackage

// File: rtl/jtcps1_obj_scan_if.sv
// Draw-side and scan-side signal bundle for jtcps1_obj_scan.
// The flip input exists only when JTCPS1_OBJ_FLIP_EN is defined.
interface jtcps1_obj_scan_if;
  logic       pxl_cen;
  logic       hs;
  logic [8:0] hdump;
  logic       start;
  logic [8:0] buf_addr;
  logic [8:0] buf_data;
  logic       buf_wr;
  logic [8:0] pxl;
`ifdef JTCPS1_OBJ_FLIP_EN
  logic       flip;

  modport master (
    output pxl_cen, hs, hdump, buf_addr, buf_data, buf_wr, flip,
    input  start, pxl
  );
  modport slave (
    input  pxl_cen, hs, hdump, buf_addr, buf_data, buf_wr, flip,
    output start, pxl
  );
`else
  modport master (
    output pxl_cen, hs, hdump, buf_addr, buf_data, buf_wr,
    input  start, pxl
  );
  modport slave (
    input  pxl_cen, hs, hdump, buf_addr, buf_data, buf_wr,
    output start, pxl
  );
`endif
endinterface

// File: rtl/jtcps1_obj_lbram.sv
// 512x9 single-port line RAM, write-first-free: read data is registered and
// only refreshed when re_i is set, so it holds across the clear cycle.
module jtcps1_obj_lbram (
  input  logic       clk,
  input  logic       we_i,
  input  logic       re_i,
  input  logic [8:0] addr_i,
  input  logic [8:0] din_i,
  output logic [8:0] dout_o
);

  logic [8:0] mem_q [512];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= din_i;
    if (re_i) dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/jtcps1_obj_scan.sv
// Object line-buffer scan-out: two ping-pong banks, read-then-clear at pixel rate.
// Define JTCPS1_OBJ_FLIP_EN to add horizontal flip of the read/clear address.
module jtcps1_obj_scan
  import jtcps1_obj_pkg::*;
#(
  parameter logic [8:0] MAXH   = OBJ_MAXH,
  parameter logic [3:0] TRANSP = OBJ_TRANSP
) (
  input logic             clk,
  input logic             rst,
  jtcps1_obj_scan_if.slave bus
);

  logic       hs_l_q, start_q, wr_bank_q, seen_q, rd_valid_q, pxl_valid_q;
  logic       clr_pend_q, clr_bank_q, rd_sel_q;
  logic [8:0] clr_addr_q;
  logic       hs_edge, rd_bank, flip;
  logic [8:0] rd_addr;
  logic [1:0] we, re;
  logic [8:0] addr [2];
  logic [8:0] din  [2];
  logic [8:0] dout [2];

`ifdef JTCPS1_OBJ_FLIP_EN
  assign flip = bus.flip;
`else
  assign flip = 1'b0;
`endif

  assign hs_edge = bus.hs & ~hs_l_q;
  assign rd_bank = ~wr_bank_q;
  assign rd_addr = obj_rd_addr(bus.hdump, flip, MAXH);

  // The clear targets the bank latched at read time, so a swap right after
  // the read cannot redirect it into the freshly selected read bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we[b]   = (clr_pend_q && (clr_bank_q == 1'(b))) ||
                ((wr_bank_q == 1'(b)) && bus.buf_wr &&
                 (bus.buf_data[COL_W-1:0] != TRANSP));
      re[b]   = (rd_bank == 1'(b)) && bus.pxl_cen;
      addr[b] = bus.buf_addr;
      din[b]  = bus.buf_data;
      if (clr_pend_q && (clr_bank_q == 1'(b))) begin
        addr[b] = clr_addr_q;
        din[b]  = OBJ_CLR;
      end else if (wr_bank_q != 1'(b)) begin
        addr[b] = rd_addr;
      end
    end
  end

  jtcps1_obj_lbram u_bank0 (
    .clk    (clk),
    .we_i   (we[0]),
    .re_i   (re[0]),
    .addr_i (addr[0]),
    .din_i  (din[0]),
    .dout_o (dout[0])
  );

  jtcps1_obj_lbram u_bank1 (
    .clk    (clk),
    .we_i   (we[1]),
    .re_i   (re[1]),
    .addr_i (addr[1]),
    .din_i  (din[1]),
    .dout_o (dout[1])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l_q      <= 1'b0;
      start_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      seen_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      pxl_valid_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_bank_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
      clr_addr_q  <= 9'd0;
    end else begin
      hs_l_q     <= bus.hs;
      start_q    <= hs_edge;
      clr_pend_q <= bus.pxl_cen;
      if (hs_edge) begin
        wr_bank_q <= ~wr_bank_q;
        seen_q    <= 1'b1;
        if (seen_q) rd_valid_q <= 1'b1;
      end
      // Output select and mask are captured with the read so pxl stays put
      // until the next pixel even across a bank swap.
      if (bus.pxl_cen) begin
        clr_addr_q  <= rd_addr;
        clr_bank_q  <= rd_bank;
        rd_sel_q    <= rd_bank;
        pxl_valid_q <= rd_valid_q;
      end
    end
  end

  assign bus.start = start_q;
  assign bus.pxl   = pxl_valid_q ? dout[rd_sel_q] : OBJ_CLR;

endmodule
